// File: rtl/rvv_backend_mul_rs_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_mul_rs_fifo_pkg
// Brief    : Shared MUL/MAC reservation-station types, sizes and helpers.
// Revision : 1.0
// ============================================================================
package rvv_backend_mul_rs_fifo_pkg;

    localparam int NUM_MUL      = 2;
    localparam int MUL_RS_DEPTH = 8;

    typedef struct packed {
        logic [3:0]  rob_entry;
        logic [5:0]  funct6;
        logic [2:0]  vsew;
        logic        vm;
        logic [31:0] vs1_data;
        logic [31:0] vs2_data;
        logic [31:0] vd_data;
    } MUL_RS_t;

    // In-order slot acceptance: slot1 only ever rides along with slot0.
    function automatic logic [1:0] slot_accept(
        input logic [1:0] req,
        input logic       room0,
        input logic       room1
    );
        return {req[1] & req[0] & room1, req[0] & room0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvv_backend_mul_rs_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_mul_rs_fifo_if
// Brief    : Dispatch / execute / flush bundle of the MUL reservation station.
// Revision : 1.0
// ============================================================================
interface rvv_backend_mul_rs_fifo_if
    import rvv_backend_mul_rs_fifo_pkg::*;
#(
    parameter int DEPTH = MUL_RS_DEPTH
) ();
    localparam int PTR_W = $clog2(DEPTH);

    logic                trap_flush_rvv;
    logic [NUM_MUL-1:0]  dp2rs_push;
    MUL_RS_t             dp2rs_uop_data [NUM_MUL];
    logic                rs2dp_fifo_full;
    logic                rs2dp_fifo_1left_to_full;
    MUL_RS_t             rs2ex_uop_data [NUM_MUL];
    logic                rs2ex_fifo_empty;
    logic                rs2ex_fifo_1left_to_empty;
    logic [NUM_MUL-1:0]  ex2rs_fifo_pop;
    logic [PTR_W:0]      rs_count;

    modport master (
        output trap_flush_rvv, dp2rs_push, dp2rs_uop_data, ex2rs_fifo_pop,
        input  rs2dp_fifo_full, rs2dp_fifo_1left_to_full, rs2ex_uop_data,
               rs2ex_fifo_empty, rs2ex_fifo_1left_to_empty, rs_count
    );

    modport slave (
        input  trap_flush_rvv, dp2rs_push, dp2rs_uop_data, ex2rs_fifo_pop,
        output rs2dp_fifo_full, rs2dp_fifo_1left_to_full, rs2ex_uop_data,
               rs2ex_fifo_empty, rs2ex_fifo_1left_to_empty, rs_count
    );
endinterface
`default_nettype wire

// File: rtl/rvv_backend_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_fifo_ptr_ctrl
// Brief    : Generic 2-in/2-out FIFO pointer, occupancy and flag manager.
// Revision : 1.0
// ============================================================================
module rvv_backend_fifo_ptr_ctrl
    import rvv_backend_mul_rs_fifo_pkg::*;
#(
    parameter int DEPTH = MUL_RS_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic [1:0]       i_push,
    input  wire logic [1:0]       i_pop,
    output logic      [1:0]       o_push_acc,
    output logic      [1:0]       o_pop_acc,
    output logic      [PTR_W-1:0] o_wptr,
    output logic      [PTR_W-1:0] o_rptr,
    output logic      [PTR_W:0]   o_count,
    output logic                  o_full,
    output logic                  o_1left_to_full,
    output logic                  o_empty,
    output logic                  o_1left_to_empty
);
    localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] c_DEPTH_M1  = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] c_DEPTH_M2  = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] c_ONE       = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] c_TWO       = (PTR_W+1)'(2);

    logic [PTR_W-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic [PTR_W:0]   r_count, w_count_nxt, w_n_push, w_n_pop;
    logic [1:0]       w_push_acc, w_pop_acc;

    // Acceptance looks only at registered count: no same-cycle pop-to-push bypass.
    assign w_push_acc = slot_accept(i_push, r_count != c_DEPTH_CNT, r_count <= c_DEPTH_M2)
                        & {2{~i_flush}};
    assign w_pop_acc  = slot_accept(i_pop, r_count != '0, r_count >= c_TWO)
                        & {2{~i_flush}};

    assign w_n_push = (PTR_W+1)'(w_push_acc[0]) + (PTR_W+1)'(w_push_acc[1]);
    assign w_n_pop  = (PTR_W+1)'(w_pop_acc[0])  + (PTR_W+1)'(w_pop_acc[1]);

    always_comb begin
        w_wptr_nxt  = r_wptr + w_n_push[PTR_W-1:0];
        w_rptr_nxt  = r_rptr + w_n_pop[PTR_W-1:0];
        w_count_nxt = r_count + w_n_push - w_n_pop;
        if (i_flush) begin
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_push_acc       = w_push_acc;
    assign o_pop_acc        = w_pop_acc;
    assign o_wptr           = r_wptr;
    assign o_rptr           = r_rptr;
    assign o_count          = r_count;
    assign o_full           = (r_count == c_DEPTH_CNT);
    assign o_1left_to_full  = (r_count == c_DEPTH_M1);
    assign o_empty          = (r_count == '0);
    assign o_1left_to_empty = (r_count == c_ONE);

    a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= c_DEPTH_CNT);

endmodule
`default_nettype wire

// File: rtl/rvv_backend_mul_rs_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_mul_rs_fifo
// Brief    : MUL/MAC reservation-station FIFO, 2 pushes and 2 pops per cycle.
// Revision : 1.0
// ============================================================================
module rvv_backend_mul_rs_fifo
    import rvv_backend_mul_rs_fifo_pkg::*;
#(
    parameter int DEPTH          = MUL_RS_DEPTH,
    parameter bit STRICT_REQ_CHK = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    rvv_backend_mul_rs_fifo_if.slave   mif
);
    localparam int PTR_W = $clog2(DEPTH);

    MUL_RS_t          r_storage [DEPTH];
    logic [PTR_W-1:0] w_wptr, w_rptr, w_wptr1, w_rptr1;
    logic [PTR_W:0]   w_count;
    logic [1:0]       w_push_acc, w_pop_acc;

    rvv_backend_fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk              (clk),
        .rst              (rst),
        .i_flush          (mif.trap_flush_rvv),
        .i_push           (mif.dp2rs_push),
        .i_pop            (mif.ex2rs_fifo_pop),
        .o_push_acc       (w_push_acc),
        .o_pop_acc        (w_pop_acc),
        .o_wptr           (w_wptr),
        .o_rptr           (w_rptr),
        .o_count          (w_count),
        .o_full           (mif.rs2dp_fifo_full),
        .o_1left_to_full  (mif.rs2dp_fifo_1left_to_full),
        .o_empty          (mif.rs2ex_fifo_empty),
        .o_1left_to_empty (mif.rs2ex_fifo_1left_to_empty)
    );

    // Pointer-width arithmetic gives the mod-DEPTH wrap for slot1.
    assign w_wptr1 = w_wptr + PTR_W'(1);
    assign w_rptr1 = w_rptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_storage[i] <= '0;
            end
        end else begin
            if (w_push_acc[0]) r_storage[w_wptr]  <= mif.dp2rs_uop_data[0];
            if (w_push_acc[1]) r_storage[w_wptr1] <= mif.dp2rs_uop_data[1];
        end
    end

    assign mif.rs2ex_uop_data[0] = r_storage[w_rptr];
    assign mif.rs2ex_uop_data[1] = r_storage[w_rptr1];
    assign mif.rs_count          = w_count;

    generate
        if (STRICT_REQ_CHK) begin : g_req_chk
            a_push_order: assert property (@(posedge clk) disable iff (rst)
                mif.dp2rs_push != 2'b10);
            a_push_room: assert property (@(posedge clk) disable iff (rst || mif.trap_flush_rvv)
                w_push_acc == {mif.dp2rs_push[1] & mif.dp2rs_push[0], mif.dp2rs_push[0]});
            a_pop_order: assert property (@(posedge clk) disable iff (rst)
                mif.ex2rs_fifo_pop != 2'b10);
            a_pop_avail: assert property (@(posedge clk) disable iff (rst || mif.trap_flush_rvv)
                w_pop_acc == {mif.ex2rs_fifo_pop[1] & mif.ex2rs_fifo_pop[0], mif.ex2rs_fifo_pop[0]});
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rvv_backend_mul_rs_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvv_backend_mul_rs_fifo
// Brief    : Scoreboard bench for the MUL reservation-station FIFO.
// Revision : 1.0
// ============================================================================
module tb_rvv_backend_mul_rs_fifo;
    import rvv_backend_mul_rs_fifo_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        int      cnt;
        bit      chk_zero;
        MUL_RS_t d0;
        MUL_RS_t d1;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    exp_t    exp_q[$];
    MUL_RS_t model_q[$];
    bit      model_zero = 1'b0;
    int      n_checks = 0;
    int      n_fail   = 0;

    always #5 clk = ~clk;

    rvv_backend_mul_rs_fifo_if #(.DEPTH(DEPTH)) mif ();

    rvv_backend_mul_rs_fifo #(
        .DEPTH          (DEPTH),
        .STRICT_REQ_CHK (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic MUL_RS_t rand_uop();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[$bits(MUL_RS_t)-1:0];
    endfunction

    // Drive one cycle of stimulus and record what the FIFO must look like afterwards.
    task automatic step(input logic r, input logic f, input logic [1:0] p, input logic [1:0] o);
        exp_t    e;
        int      n, acc, pops;
        MUL_RS_t u0, u1;
        @(negedge clk);
        u0 = rand_uop();
        u1 = rand_uop();
        rst                   = r;
        mif.trap_flush_rvv    = f;
        mif.dp2rs_push        = p;
        mif.ex2rs_fifo_pop    = o;
        mif.dp2rs_uop_data[0] = u0;
        mif.dp2rs_uop_data[1] = u1;
        n = model_q.size();
        if (r) begin
            model_q.delete();
            model_zero = 1'b1;
        end else if (f) begin
            model_q.delete();
            model_zero = 1'b0;
        end else begin
            acc = 0;
            if (p[0] && n < DEPTH) acc = (p[1] && n <= DEPTH - 2) ? 2 : 1;
            pops = 0;
            if (o[0] && n >= 1) pops = (o[1] && n >= 2) ? 2 : 1;
            repeat (pops) void'(model_q.pop_front());
            if (acc >= 1) model_q.push_back(u0);
            if (acc == 2) model_q.push_back(u1);
            if (acc > 0) model_zero = 1'b0;
        end
        e.cnt      = model_q.size();
        e.chk_zero = model_zero;
        e.d0       = (e.cnt >= 1) ? model_q[0] : '0;
        e.d1       = (e.cnt >= 2) ? model_q[1] : '0;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against each recorded expectation just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rs_count",        128'(mif.rs_count),                  128'(e.cnt));
                chk("empty",           128'(mif.rs2ex_fifo_empty),          128'(e.cnt == 0));
                chk("1left_to_empty",  128'(mif.rs2ex_fifo_1left_to_empty), 128'(e.cnt == 1));
                chk("full",            128'(mif.rs2dp_fifo_full),           128'(e.cnt == DEPTH));
                chk("1left_to_full",   128'(mif.rs2dp_fifo_1left_to_full),  128'(e.cnt == DEPTH - 1));
                if (e.cnt >= 1 || e.chk_zero)
                    chk("uop_data0", 128'(mif.rs2ex_uop_data[0]), 128'(e.d0));
                if (e.cnt >= 2 || e.chk_zero)
                    chk("uop_data1", 128'(mif.rs2ex_uop_data[1]), 128'(e.d1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pr, qr;
        logic [1:0] p, o;
        mif.trap_flush_rvv    = 1'b0;
        mif.dp2rs_push        = 2'b00;
        mif.ex2rs_fifo_pop    = 2'b00;
        mif.dp2rs_uop_data[0] = '0;
        mif.dp2rs_uop_data[1] = '0;

        // Reset and idle
        step(1, 0, 2'b00, 2'b00);
        step(1, 0, 2'b11, 2'b11);
        repeat (2) step(0, 0, 2'b00, 2'b00);

        // A alone, then B,C, then pop two
        step(0, 0, 2'b01, 2'b00);
        step(0, 0, 2'b11, 2'b00);
        step(0, 0, 2'b00, 2'b11);
        step(0, 0, 2'b00, 2'b00);

        // Fill to 7, request 11 at 7, then overflow attempts
        repeat (3) step(0, 0, 2'b11, 2'b00);
        step(0, 0, 2'b11, 2'b00);
        step(0, 0, 2'b11, 2'b00);
        step(0, 0, 2'b01, 2'b00);
        step(0, 0, 2'b00, 2'b00);

        // Drain to 2 then steady 2-in/2-out across the wrap
        repeat (3) step(0, 0, 2'b00, 2'b11);
        repeat (20) step(0, 0, 2'b11, 2'b11);

        // Reach 5 then flush while pushing and popping
        step(0, 0, 2'b11, 2'b00);
        step(0, 0, 2'b01, 2'b00);
        step(0, 1, 2'b11, 2'b11);
        step(0, 0, 2'b00, 2'b00);

        // Illegal pop patterns
        step(0, 0, 2'b11, 2'b00);
        step(0, 0, 2'b01, 2'b00);
        step(0, 0, 2'b00, 2'b10);
        step(0, 1, 2'b00, 2'b00);
        step(0, 0, 2'b00, 2'b01);
        step(0, 0, 2'b00, 2'b11);

        // Randomised phases: push-heavy, balanced, pop-heavy
        for (int i = 0; i < 600; i++) begin
            int phase;
            phase = (i / 50) % 3;
            pr = $urandom_range(0, 99);
            qr = $urandom_range(0, 99);
            if (phase == 0) begin
                p = (pr < 60) ? 2'b11 : (pr < 85) ? 2'b01 : (pr < 95) ? 2'b00 : 2'b10;
                o = (qr < 15) ? 2'b11 : (qr < 30) ? 2'b01 : (qr < 95) ? 2'b00 : 2'b10;
            end else if (phase == 1) begin
                p = 2'($urandom_range(0, 3));
                o = 2'($urandom_range(0, 3));
            end else begin
                p = (pr < 15) ? 2'b11 : (pr < 30) ? 2'b01 : (pr < 95) ? 2'b00 : 2'b10;
                o = (qr < 60) ? 2'b11 : (qr < 85) ? 2'b01 : (qr < 95) ? 2'b00 : 2'b10;
            end
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) == 0)  ? 1'b1 : 1'b0, p, o);
        end

        // Mid-operation reset overriding flush, push and pop
        repeat (3) step(0, 0, 2'b11, 2'b01);
        step(1, 1, 2'b11, 2'b11);
        repeat (2) step(0, 0, 2'b00, 2'b00);
        step(0, 0, 2'b00, 2'b00);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drain", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvv_backend_mul_rs_fifo.md
Name: rvv_backend_mul_rs_fifo

Overview:
- Reservation-station FIFO for multiply/MAC uops.
- Sits between dispatch and the MUL/MAC execute wrapper.
- Accepts up to 2 uops per cycle in order from dispatch, and presents the two oldest entries to execute.
- Retires 0, 1 or 2 entries per cycle on execute's in-order pop, and is flushed by trap.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- trap_flush_rvv  in  1  flush all entries.
- dp2rs_push  in  `NUM_MUL  push request per slot; bit1 legal only with bit0.
- dp2rs_uop_data  in  MUL_RS_t[`NUM_MUL]  uops to write; slot0 is older.
- rs2dp_fifo_full  out  1  count==DEPTH.
- rs2dp_fifo_1left_to_full  out  1  count==DEPTH-1.
- rs2ex_uop_data  out  MUL_RS_t[`NUM_MUL]  [0]=entry at rptr, [1]=entry at rptr+1.
- rs2ex_fifo_empty  out  1  count==0.
- rs2ex_fifo_1left_to_empty  out  1  count==1.
- ex2rs_fifo_pop  in  `NUM_MUL  pop per slot; bit1 legal only with bit0.
- rs_count  out  PTR_W+1  current occupancy, for debug/perf.

Behaviour:
- State registers: storage[DEPTH] of MUL_RS_t, wptr, rptr (PTR_W bits, wrap naturally modulo DEPTH), count (PTR_W+1 bits).
- All flags are decoded combinationally from registered count. No same-cycle bypass: a pop does not free space for a push in the same cycle, and pushed data is visible on rs2ex_uop_data the next cycle (push-to-execute latency 1).
- Push acceptance:
  - slot0 writes if dp2rs_push[0] && !full.
  - slot1 writes if dp2rs_push[1] && dp2rs_push[0] && count<=DEPTH-2.
  - Accepted slot0 goes to storage[wptr], slot1 to storage[wptr+1]. wptr advances by the number accepted.
  - Dispatch uses full and 1left_to_full to gate requests; pushes beyond the space available are dropped and flagged by an assertion.
- Pop acceptance:
  - pop0 valid if ex2rs_fifo_pop[0] && count>=1.
  - pop1 valid if ex2rs_fifo_pop[1] && ex2rs_fifo_pop[0] && count>=2.
  - rptr advances by the number of valid pops.
  - Pop when empty, pop1 when count==1, or pop1 without pop0: ignored, with an assertion.
- count_next = count + pushes_accepted - pops_valid. Simultaneous 2 push + 2 pop at any occupancy keeps count unchanged.
- Wrap-around: slot1 read and write indices use (ptr+1) mod DEPTH. rptr=DEPTH-1 presents storage[DEPTH-1] and storage[0].
- rs2ex_uop_data is always driven from storage regardless of count. Execute qualifies it with empty and 1left_to_empty.
- trap_flush_rvv has priority over push/pop in the same cycle: next cycle wptr=rptr=0 and count=0. Pushes and pops in the flush cycle are discarded. Storage contents are untouched.
- Reset (rst=1 at posedge): wptr=rptr=count=0 and all storage cleared to '0.
  - Outputs after reset: rs2ex_fifo_empty=1, rs2ex_fifo_1left_to_empty=0, full=0, 1left_to_full=0, rs_count=0, rs2ex_uop_data='0.
  - Reset mid-operation behaves identically and overrides flush, push and pop.
- No combinational path from ex2rs_fifo_pop to any output.

Decomposition:
- MUL_RS_t, `NUM_MUL and the uop field definitions stay in the shared rvv_backend.svh package.
- Add `MUL_RS_DEPTH there as the default for DEPTH.
- Assertions (illegal push/pop, count<=DEPTH) go in rvv_backend_sva.svh style checks.
- One natural sub-module: rvv_backend_fifo_ptr_ctrl, a generic 2-in/2-out pointer and count manager with flag decode. It is reusable by the other reservation stations. Storage and muxing stay in the top.

Test Plan:
- Reset then idle -> empty=1, 1left_to_empty=0, full=0, 1left_to_full=0, rs_count=0, rs2ex_uop_data=0.
- Push A only (01), next cycle push B,C (11) -> after the first push 1left_to_empty=1 and data[0]=A; after the second, count=3, data[0]=A, data[1]=B; pop 11 -> count=1, data[0]=C.
- Fill to 7 with DEPTH=8, request push 11 -> only slot0 accepted, count=8, full=1; further pushes dropped and assertion fires.
- Run 20 cycles of steady 2-push/2-pop starting at count=2 -> count stays 2, FIFO order preserved across pointer wrap (rptr=7 shows storage[7], storage[0]).
- count=5 with push 11 and pop 11 asserted and trap_flush_rvv=1 in the same cycle -> next cycle count=0, empty=1, no entry retained.
- Pop 10 (pop1 without pop0) at count=3, and pop 01 at count=0 -> both ignored, count unchanged, assertions fire.
